// File: rtl/crop_video_axis_window.sv
// AXI4-Stream video crop: keeps a programmable beat/line window and regenerates SOF/EOL.
// Optional statistics outputs are enabled with CROP_VIDEO_AXIS_WINDOW_STATS_EN.
module crop_video_axis_window #(
    parameter int PIX_WIDTH    = 8,
    parameter int PIX_PER_BEAT = 4,
    parameter int DIM_WIDTH    = 12
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DIM_WIDTH-1:0]                cfg_x,
    input  logic [DIM_WIDTH-1:0]                cfg_y,
    input  logic [DIM_WIDTH-1:0]                cfg_w,
    input  logic [DIM_WIDTH-1:0]                cfg_h,
    input  logic [PIX_WIDTH*PIX_PER_BEAT-1:0]   s00_axis_tdata,
    input  logic [PIX_WIDTH*PIX_PER_BEAT/8-1:0] s00_axis_tstrb,
    input  logic                                s00_axis_tvalid,
    output logic                                s00_axis_tready,
    input  logic                                s00_axis_tuser,
    input  logic                                s00_axis_tlast,
    output logic [PIX_WIDTH*PIX_PER_BEAT-1:0]   m00_axis_tdata,
    output logic [PIX_WIDTH*PIX_PER_BEAT/8-1:0] m00_axis_tstrb,
    output logic                                m00_axis_tvalid,
    input  logic                                m00_axis_tready,
    output logic                                m00_axis_tuser,
    output logic                                m00_axis_tlast
`ifdef CROP_VIDEO_AXIS_WINDOW_STATS_EN
    ,
    output logic [15:0]                         stat_frames,
    output logic [31:0]                         stat_dropped,
    output logic                                stat_short_line
`endif
);

    localparam int DW = PIX_WIDTH * PIX_PER_BEAT;
    localparam int SW = DW / 8;
    localparam int EW = DW + SW + 2;
    localparam logic [DIM_WIDTH:0]   ONE_E = {{DIM_WIDTH{1'b0}}, 1'b1};
    localparam logic [DIM_WIDTH-1:0] ONE_D = {{(DIM_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {WAIT_SOF, ACTIVE} state_t;

    state_t               state_reg, state_next;
    logic [DIM_WIDTH-1:0] col_reg, row_reg;
    logic [DIM_WIDTH-1:0] sx_reg, sy_reg, sw_reg, sh_reg;
    logic [EW-1:0]        fifo_mem [2];
    logic                 wr_ptr_reg, rd_ptr_reg;
    logic [1:0]           count_reg;

    logic                 accept, push, pop, in_frame, keep, win_last, out_user;
    logic [DIM_WIDTH-1:0] cur_col, cur_row, cur_sx, cur_sy, cur_sw, cur_sh;
    logic [DIM_WIDTH:0]   col_e, row_e, x_lo, x_hi, y_lo, y_hi;
    logic [EW-1:0]        wr_entry, rd_entry;

    assign s00_axis_tready = rst & (count_reg != 2'd2);
    assign accept          = s00_axis_tvalid & s00_axis_tready;
    assign pop             = m00_axis_tvalid & m00_axis_tready;

    // A SOF beat is judged against the freshly presented cfg at (0,0).
    assign cur_sx  = s00_axis_tuser ? cfg_x : sx_reg;
    assign cur_sy  = s00_axis_tuser ? cfg_y : sy_reg;
    assign cur_sw  = s00_axis_tuser ? cfg_w : sw_reg;
    assign cur_sh  = s00_axis_tuser ? cfg_h : sh_reg;
    assign cur_col = s00_axis_tuser ? '0 : col_reg;
    assign cur_row = s00_axis_tuser ? '0 : row_reg;

    // One extra bit keeps x+w and y+h from wrapping.
    assign col_e = {1'b0, cur_col};
    assign row_e = {1'b0, cur_row};
    assign x_lo  = {1'b0, cur_sx};
    assign x_hi  = x_lo + {1'b0, cur_sw};
    assign y_lo  = {1'b0, cur_sy};
    assign y_hi  = y_lo + {1'b0, cur_sh};

    assign in_frame = s00_axis_tuser | (state_reg == ACTIVE);
    assign keep     = in_frame && (col_e >= x_lo) && (col_e < x_hi) &&
                      (row_e >= y_lo) && (row_e < y_hi);
    assign win_last = (col_e + ONE_E) == x_hi;
    assign out_user = (cur_col == cur_sx) && (cur_row == cur_sy);
    assign push     = accept & keep;
    assign wr_entry = {out_user, win_last | s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata};

    always_comb begin
        state_next = state_reg;
        if (accept && s00_axis_tuser) begin
            state_next = ACTIVE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= WAIT_SOF;
            col_reg   <= '0;
            row_reg   <= '0;
            sx_reg    <= '0;
            sy_reg    <= '0;
            sw_reg    <= '0;
            sh_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept && s00_axis_tuser) begin
                sx_reg <= cfg_x;
                sy_reg <= cfg_y;
                sw_reg <= cfg_w;
                sh_reg <= cfg_h;
            end
            if (accept && in_frame) begin
                if (s00_axis_tlast) begin
                    col_reg <= '0;
                    row_reg <= cur_row + ONE_D;
                end else begin
                    col_reg <= (&cur_col) ? cur_col : cur_col + ONE_D;
                    row_reg <= cur_row;
                end
            end
        end
    end

    // Two-entry output skid buffer.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    fifo_mem[gi] <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    fifo_mem[gi] <= wr_entry;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            if (push && !pop)      count_reg <= count_reg + 2'd1;
            else if (pop && !push) count_reg <= count_reg - 2'd1;
        end
    end

    assign rd_entry        = fifo_mem[rd_ptr_reg];
    assign m00_axis_tvalid = (count_reg != 2'd0);
    assign m00_axis_tdata  = rd_entry[DW-1:0];
    assign m00_axis_tstrb  = rd_entry[DW+SW-1:DW];
    assign m00_axis_tlast  = rd_entry[EW-2];
    assign m00_axis_tuser  = rd_entry[EW-1];

`ifdef CROP_VIDEO_AXIS_WINDOW_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_frames     <= '0;
            stat_dropped    <= '0;
            stat_short_line <= 1'b0;
        end else begin
            if (pop && m00_axis_tuser) stat_frames <= stat_frames + 16'd1;
            if (accept && !keep && (stat_dropped != '1)) stat_dropped <= stat_dropped + 32'd1;
            if (push && s00_axis_tlast && !win_last) stat_short_line <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_crop_video_axis_window.sv
// Scoreboard bench for crop_video_axis_window: expected beats are queued at input
// acceptance and compared as they leave m00.
module tb_crop_video_axis_window;

    localparam int DIMW = 12;
    localparam time PERIOD = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [DIMW-1:0] cfg_x = '0, cfg_y = '0, cfg_w = '0, cfg_h = '0;
    logic [31:0]     s_tdata = '0;
    logic [3:0]      s_tstrb = '0;
    logic            s_tvalid = 1'b0, s_tuser = 1'b0, s_tlast = 1'b0;
    logic            s_tready;
    logic [31:0]     m_tdata;
    logic [3:0]      m_tstrb;
    logic            m_tvalid, m_tuser, m_tlast;
    logic            m_tready = 1'b1;
`ifdef CROP_VIDEO_AXIS_WINDOW_STATS_EN
    logic [15:0]     stat_frames;
    logic [31:0]     stat_dropped;
    logic            stat_short_line;
`endif

    crop_video_axis_window dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_x           (cfg_x),
        .cfg_y           (cfg_y),
        .cfg_w           (cfg_w),
        .cfg_h           (cfg_h),
        .s00_axis_tdata  (s_tdata),
        .s00_axis_tstrb  (s_tstrb),
        .s00_axis_tvalid (s_tvalid),
        .s00_axis_tready (s_tready),
        .s00_axis_tuser  (s_tuser),
        .s00_axis_tlast  (s_tlast),
        .m00_axis_tdata  (m_tdata),
        .m00_axis_tstrb  (m_tstrb),
        .m00_axis_tvalid (m_tvalid),
        .m00_axis_tready (m_tready),
        .m00_axis_tuser  (m_tuser),
        .m00_axis_tlast  (m_tlast)
`ifdef CROP_VIDEO_AXIS_WINDOW_STATS_EN
        ,
        .stat_frames     (stat_frames),
        .stat_dropped    (stat_dropped),
        .stat_short_line (stat_short_line)
`endif
    );

    always #(PERIOD/2) clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
        logic        u;
        logic        l;
        bit          chk_lat;
        time         t_acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   out_cnt  = 0;
    bit   toggle_ready = 0;
    bit   chk_ready = 0;
    bit   lat_mode = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        m_tready = toggle_ready ? ~m_tready : 1'b1;
    end

    // Output monitor / scoreboard pop
    always @(negedge clk) begin
        exp_t e;
        if (rst && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_beat", {32'h0, m_tdata}, 64'h0);
            end else begin
                e = exp_q.pop_front();
                out_cnt++;
                $display("beat %0d: data=%08h strb=%h user=%0d last=%0d", out_cnt, m_tdata, m_tstrb, m_tuser, m_tlast);
                check_eq("tdata", m_tdata, e.d);
                check_eq("tstrb", m_tstrb, e.s);
                check_eq("tuser", m_tuser, e.u);
                check_eq("tlast", m_tlast, e.l);
                if (e.chk_lat) check_eq("latency", $time - e.t_acc, PERIOD);
            end
        end
    end

    // Stability of m00 while stalled
    logic        prev_v = 0, prev_r = 0, prev_u = 0, prev_l = 0;
    logic [31:0] prev_d = '0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_v = 0;
        end else begin
            if (prev_v && !prev_r) begin
                check_eq("hold_valid", m_tvalid, 1'b1);
                check_eq("hold_data", m_tdata, prev_d);
                check_eq("hold_flags", {m_tuser, m_tlast}, {prev_u, prev_l});
            end
            prev_v = m_tvalid; prev_r = m_tready; prev_d = m_tdata;
            prev_u = m_tuser;  prev_l = m_tlast;
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic u, input logic l,
                             input bit keep, input bit eu, input bit el);
        bit   acc = 0;
        int   n = 0;
        exp_t e;
        @(negedge clk);
        s_tdata = d; s_tstrb = s; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        while (!acc) begin
            if (n > 0) @(negedge clk);
            if (chk_ready) check_eq("s_ready_drain", s_tready, 1'b1);
            acc = s_tready;
            n++;
            if (!acc && n > 200) begin
                check_eq("accept_timeout", 1, 0);
                break;
            end
        end
        if (acc && keep) begin
            e.d = d; e.s = s; e.u = eu; e.l = el;
            e.chk_lat = lat_mode; e.t_acc = $time;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input int fid, input int nrows, input int ncols,
                              input int short_row, input int short_len,
                              input int x, input int y, input int w, input int h,
                              input int stop_after);
        int beats = 0;
        for (int r = 0; r < nrows; r++) begin
            int len = (r == short_row) ? short_len : ncols;
            for (int c = 0; c < len; c++) begin
                bit k  = (c >= x) && (c < x + w) && (r >= y) && (r < y + h);
                bit eu = k && (c == x) && (r == y);
                bit el = k && ((c == x + w - 1) || (c == len - 1));
                if (beats == stop_after) return;
                send_beat({8'(fid), 8'(r), 8'(c), 8'h5A}, 4'(r + c + 1),
                          (r == 0 && c == 0), (c == len - 1), k, eu, el);
                beats++;
            end
        end
    endtask

    task automatic pre_sof(input int n);
        for (int i = 0; i < n; i++)
            send_beat({8'hEE, 8'(i), 16'hBEEF}, 4'hF, 1'b0, (i == n - 1), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle_drain(input string tag, input int exp_beats, input int start_cnt);
        int n = 0;
        @(negedge clk);
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check_eq({tag, "_left"}, exp_q.size(), 0);
        check_eq({tag, "_count"}, out_cnt - start_cnt, exp_beats);
    endtask

    initial begin
        int c0;
        repeat (3) @(negedge clk);
        check_eq("rst_tvalid", m_tvalid, 1'b0);
        check_eq("rst_tdata", m_tdata, 32'h0);
        check_eq("rst_flags", {m_tuser, m_tlast, m_tstrb}, 6'h0);
        check_eq("rst_sready", s_tready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("sready_after_rst", s_tready, 1'b1);

        cfg_x = 2; cfg_y = 1; cfg_w = 3; cfg_h = 2;
        // leading beats before first SOF, then basic frame with latency check
        lat_mode = 1; c0 = out_cnt;
        pre_sof(5);
        send_frame(1, 4, 8, -1, 0, 2, 1, 3, 2, -1);
        idle_drain("presof_frame", 6, c0);

        c0 = out_cnt;
        send_frame(2, 4, 8, -1, 0, 2, 1, 3, 2, -1);
        idle_drain("basic_frame", 6, c0);
        lat_mode = 0;

        toggle_ready = 1; c0 = out_cnt;
        send_frame(3, 4, 8, -1, 0, 2, 1, 3, 2, -1);
        idle_drain("toggle_frame", 6, c0);
        toggle_ready = 0;

        cfg_w = 0; chk_ready = 1; c0 = out_cnt;
        send_frame(4, 4, 8, -1, 0, 2, 1, 0, 2, -1);
        chk_ready = 0;
        idle_drain("w0_frame", 0, c0);

        cfg_w = 3; c0 = out_cnt;
        send_frame(5, 4, 8, 1, 4, 2, 1, 3, 2, -1);
        idle_drain("short_line", 5, c0);
`ifdef CROP_VIDEO_AXIS_WINDOW_STATS_EN
        check_eq("stat_short_set", stat_short_line, 1'b1);
        check_eq("stat_frames", stat_frames, 16'd4);
`endif

        // reset in the middle of line 2
        send_frame(6, 4, 8, -1, 0, 2, 1, 3, 2, 19);
        @(posedge clk);
        #2;
        rst = 1'b0;
        s_tvalid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check_eq("midrst_tvalid", m_tvalid, 1'b0);
        check_eq("midrst_tdata", m_tdata, 32'h0);
        check_eq("midrst_flags", {m_tuser, m_tlast, m_tstrb}, 6'h0);
        check_eq("midrst_sready", s_tready, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        lat_mode = 1; c0 = out_cnt;
        pre_sof(3);
        send_frame(7, 4, 8, -1, 0, 2, 1, 3, 2, -1);
        idle_drain("after_rst", 6, c0);
        lat_mode = 0;
`ifdef CROP_VIDEO_AXIS_WINDOW_STATS_EN
        check_eq("stat_frames_rst", stat_frames, 16'd1);
        check_eq("stat_dropped", stat_dropped, 32'd29);
        check_eq("stat_short_clr", stat_short_line, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #(PERIOD * 20000);
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
